// File: rtl/io_ring_pwr_seq.sv
// IO-ring supply sequencer: ordered power-up/down of N_RAILS pad-ring segments with pg monitoring.
// Optional build macro IO_SEQ_PG_DEBOUNCE_EN adds a 4-sample debounce on synchronised power-good.
module io_ring_pwr_seq #(
  parameter int N_RAILS = 4,
  parameter int DLY_W   = 12,
  parameter int SYNC_ST = 2,
  localparam int IDX_W  = (N_RAILS > 1) ? $clog2(N_RAILS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_on,
  input  logic [DLY_W-1:0]   settle_dly,
  input  logic [DLY_W-1:0]   pg_timeout,
  input  logic [N_RAILS-1:0] rail_pg,
  output logic [N_RAILS-1:0] rail_en,
  output logic               busy,
  output logic               ring_ok,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_idx,
  input  logic               fault_clr
);

  typedef enum logic [2:0] {
    S_OFF, S_UP_EN, S_UP_WAITPG, S_UP_SETTLE, S_ON, S_DN, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [DLY_W-1:0]   settle_q, settle_d, tmo_q, tmo_d;
  logic [N_RAILS-1:0] en_q, en_d;
  logic               fault_q, fault_d;
  logic [IDX_W-1:0]   fidx_q, fidx_d;

  logic [N_RAILS-1:0] sync_q [SYNC_ST];
  logic [N_RAILS-1:0] pg_s, pg_f, pg_loss;
  logic [IDX_W-1:0]   loss_idx;

  // NOTE: synchroniser flops are plain registers, so they are reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_ST; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= rail_pg;
      for (int s = 1; s < SYNC_ST; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign pg_s = sync_q[SYNC_ST-1];

`ifdef IO_SEQ_PG_DEBOUNCE_EN
  logic [N_RAILS-1:0] pg_db;
  logic [1:0]         db_cnt [N_RAILS];

  // A new level is accepted only after four consecutive samples; any toggle back restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_db <= '0;
      for (int i = 0; i < N_RAILS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_RAILS; i++) begin
        if (pg_s[i] == pg_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 2'd3) begin
          pg_db[i]  <= pg_s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 2'd1;
        end
      end
    end
  end

  assign pg_f = pg_db;
`else
  assign pg_f = pg_s;
`endif

  assign pg_loss = en_q & ~pg_f;

  always_comb begin
    loss_idx = '0;
    for (int i = N_RAILS - 1; i >= 0; i--) begin
      if (pg_loss[i]) loss_idx = IDX_W'(i);
    end
  end

  // NOTE: every variable assigned below gets its default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    en_d     = en_q;
    fault_d  = fault_q;
    fidx_d   = fidx_q;
    cnt_inc  = cnt_q + DLY_W'(1);

    case (state_q)
      S_OFF: begin
        en_d = '0;
        if (req_on) begin
          state_d = S_UP_EN;
          idx_d   = '0;
        end
      end
      S_UP_EN: begin
        en_d     = en_q | (N_RAILS'(1) << idx_q);
        cnt_d    = '0;
        settle_d = settle_dly;
        tmo_d    = pg_timeout;
        state_d  = S_UP_WAITPG;
      end
      S_UP_WAITPG: begin
        if (pg_f[idx_q]) begin
          state_d = S_UP_SETTLE;
          cnt_d   = '0;
        end else if (tmo_q != '0 && cnt_inc == tmo_q) begin
          state_d = S_FAULT;
          en_d    = '0;
          fault_d = 1'b1;
          fidx_d  = idx_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_UP_SETTLE: begin
        if (cnt_q == settle_q) begin
          cnt_d = '0;
          // A dropped request takes effect only once the current step has settled.
          if (!req_on) begin
            state_d  = S_DN;
            en_d     = en_q & ~(N_RAILS'(1) << idx_q);
            settle_d = settle_dly;
          end else if (idx_q == IDX_W'(N_RAILS - 1)) begin
            state_d = S_ON;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_UP_EN;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ON: begin
        if (|pg_loss) begin
          state_d = S_FAULT;
          en_d    = '0;
          fault_d = 1'b1;
          fidx_d  = loss_idx;
        end else if (!req_on) begin
          state_d  = S_DN;
          idx_d    = IDX_W'(N_RAILS - 1);
          en_d     = en_q & ~(N_RAILS'(1) << (N_RAILS - 1));
          cnt_d    = '0;
          settle_d = settle_dly;
        end
      end
      S_DN: begin
        if (cnt_q == settle_q) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = S_OFF;
          end else begin
            idx_d    = idx_q - IDX_W'(1);
            en_d     = en_q & ~(N_RAILS'(1) << (idx_q - IDX_W'(1)));
            settle_d = settle_dly;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FAULT: begin
        en_d = '0;
        if (fault_clr) begin
          state_d = S_OFF;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      idx_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      en_q     <= '0;
      fault_q  <= 1'b0;
      fidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      en_q     <= en_d;
      fault_q  <= fault_d;
      fidx_q   <= fidx_d;
    end
  end

  assign rail_en   = en_q;
  assign fault     = fault_q;
  assign fault_idx = fidx_q;
  assign ring_ok   = (state_q == S_ON);
  assign busy      = !(state_q inside {S_OFF, S_ON, S_FAULT});

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Directed bench for io_ring_pwr_seq: rail_en transitions are scoreboarded against queued expectations.
module tb_io_ring_pwr_seq;
  localparam int N  = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_on = 1'b0;
  logic          fault_clr = 1'b0;
  logic [DW-1:0] settle_dly = 12'd3;
  logic [DW-1:0] pg_timeout = 12'd0;
  logic [N-1:0]  rail_pg, rail_en;
  logic [N-1:0]  pg_low = '0;
  logic          busy, ring_ok, fault;
  logic [1:0]    fault_idx;

  logic [7:0][N-1:0] hist = '0;
  int pg_dly = 5;

  io_ring_pwr_seq #(.N_RAILS(N), .DLY_W(DW), .SYNC_ST(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_on(req_on), .settle_dly(settle_dly),
    .pg_timeout(pg_timeout), .rail_pg(rail_pg), .rail_en(rail_en), .busy(busy),
    .ring_ok(ring_ok), .fault(fault), .fault_idx(fault_idx), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  // Rail model: power-good follows enable after pg_dly clocks, pg_low forces segments bad.
  always @(posedge clk) hist <= {hist[6:0], rail_en};
  assign rail_pg = hist[pg_dly-1] & ~pg_low;

  typedef struct {
    logic [N-1:0] en;
    int           gap;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_chg = 0;
  logic [N-1:0] prev_en = '0;

  localparam int W_RING = 0, W_FAULT = 1, W_IDLE = 2, W_EN = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_en(input logic [N-1:0] en, input int gap);
    exp_t e;
    e.en  = en;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (rail_en !== prev_en) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_en", 32'(rail_en), 32'(prev_en));
      end else begin
        e = sb.pop_front();
        check("sb_rail_en", 32'(rail_en), 32'(e.en));
        if (e.gap != 0) check("sb_gap", 32'(cyc - last_chg), 32'(e.gap));
      end
      last_chg = cyc;
      prev_en  = rail_en;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      mon();
    end
  endtask

  function automatic bit cond(input int kind, input logic [N-1:0] val);
    case (kind)
      W_RING:  return ring_ok === 1'b1;
      W_FAULT: return fault === 1'b1;
      W_IDLE:  return busy === 1'b0;
      default: return rail_en === val;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int kind, input logic [N-1:0] val,
                            input int budget);
    int k;
    bit hit;
    k   = 0;
    hit = cond(kind, val);
    while (!hit && k < budget) begin
      tick();
      k++;
      hit = cond(kind, val);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  task automatic expect_ramp();
    expect_en(4'b0001, 0);
    expect_en(4'b0011, 0);
    expect_en(4'b0111, 0);
    expect_en(4'b1111, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_rail_en", 32'(rail_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ring_ok", 32'(ring_ok), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fault_idx", 32'(fault_idx), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Ramp-up with 2-cycle request latency
    expect_ramp();
    req_on = 1'b1;
    tick();
    check("lat1_rail_en", 32'(rail_en), 32'h0);
    check("lat1_busy", 32'(busy), 32'h1);
    tick();
    check("lat2_rail_en", 32'(rail_en), 32'h1);
    wait_until("ramp_ring_ok", W_RING, '0, 400);
    check("on_rail_en", 32'(rail_en), 32'hf);
    check("on_busy", 32'(busy), 32'h0);
    check("on_fault", 32'(fault), 32'h0);

    // Reverse-order power-down spaced settle+1 cycles
    expect_en(4'b0111, 0);
    expect_en(4'b0011, 4);
    expect_en(4'b0001, 4);
    expect_en(4'b0000, 4);
    req_on = 1'b0;
    tick(2);
    check("dn_busy", 32'(busy), 32'h1);
    wait_until("dn_idle", W_IDLE, '0, 200);
    check("off_rail_en", 32'(rail_en), 32'h0);
    check("off_ring_ok", 32'(ring_ok), 32'h0);
    tick(10);

    // pg loss in ON
    expect_ramp();
    req_on = 1'b1;
    wait_until("ramp2_ring_ok", W_RING, '0, 400);
`ifdef IO_SEQ_PG_DEBOUNCE_EN
    pg_low[1] = 1'b1;
    tick(2);
    pg_low[1] = 1'b0;
    tick(12);
    check("glitch_ring_ok", 32'(ring_ok), 32'h1);
    check("glitch_fault", 32'(fault), 32'h0);
`endif
    expect_en(4'b0000, 0);
    pg_low[1] = 1'b1;
    wait_until("pgloss_fault", W_FAULT, '0, 50);
    check("pgloss_idx", 32'(fault_idx), 32'h1);
    check("pgloss_rail_en", 32'(rail_en), 32'h0);
    check("pgloss_ring_ok", 32'(ring_ok), 32'h0);
    check("pgloss_busy", 32'(busy), 32'h0);
    pg_low[1] = 1'b0;
    tick(20);
    check("fault_hold", 32'(fault), 32'h1);
    check("fault_hold_en", 32'(rail_en), 32'h0);
    req_on = 1'b0;
    pulse_clr();
    check("clr_fault", 32'(fault), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    tick(10);

    // pg timeout on segment 2
    pg_dly     = 1;
    pg_timeout = 12'd10;
    pg_low     = 4'b0100;
    expect_en(4'b0001, 0);
    expect_en(4'b0011, 0);
    expect_en(4'b0111, 0);
    expect_en(4'b0000, 10);
    req_on = 1'b1;
    wait_until("tmo_fault", W_FAULT, '0, 200);
    check("tmo_idx", 32'(fault_idx), 32'h2);
    check("tmo_rail_en", 32'(rail_en), 32'h0);
    req_on = 1'b0;
    pg_low = '0;
    pg_timeout = 12'd0;
    pulse_clr();
    tick(10);
    pg_dly = 5;
    tick(2);

    // Request dropped while segment 1 is settling
    expect_en(4'b0001, 0);
    expect_en(4'b0011, 0);
    req_on = 1'b1;
    wait_until("drop_reach_0011", W_EN, 4'b0011, 200);
`ifdef IO_SEQ_PG_DEBOUNCE_EN
    tick(12);
`else
    tick(8);
`endif
    expect_en(4'b0001, 0);
    expect_en(4'b0000, 4);
    req_on = 1'b0;
    wait_until("drop_idle", W_IDLE, '0, 200);
    check("drop_fault", 32'(fault), 32'h0);
    check("drop_rail_en", 32'(rail_en), 32'h0);
    tick(10);

    // Asynchronous reset mid-ramp, then fault_clr in OFF
    expect_en(4'b0001, 0);
    expect_en(4'b0011, 0);
    req_on = 1'b1;
    wait_until("rst_reach_0011", W_EN, 4'b0011, 200);
    expect_en(4'b0000, 0);
    #2 rst_n = 1'b0;
    #1 mon();
    check("arst_rail_en", 32'(rail_en), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_fault", 32'(fault), 32'h0);
    req_on = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    pulse_clr();
    tick(3);
    check("offclr_fault", 32'(fault), 32'h0);
    check("offclr_busy", 32'(busy), 32'h0);
    check("offclr_rail_en", 32'(rail_en), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
